// File: rtl/sram_like_arbiter_if.sv
// Sram-like bus bundle: the master drives the request fields and the slave
// answers with addr_ok, data_ok and rdata.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter sharing one sram-like memory port between the
// instruction-side and data-side masters, one transaction in flight.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_like_arbiter_if.slave    inst_bus,
  sram_like_arbiter_if.slave    data_bus,
  sram_like_arbiter_if.master   mem_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              mem_req_q;
  logic              req_wr_q;
  logic [1:0]        req_size_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic              win_valid_s;
  logic              win_grant_s;
  logic              sel_wr_s;
  logic [1:0]        sel_size_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              done_s;

  // Pick the winner in IDLE; on a tie the master opposite last_grant wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_grant_s = last_grant_q;
    if (state_q == ST_IDLE) begin
      if (inst_bus.req && data_bus.req) begin
        win_valid_s = 1'b1;
        win_grant_s = ~last_grant_q;
      end else if (inst_bus.req) begin
        win_valid_s = 1'b1;
        win_grant_s = 1'b0;
      end else if (data_bus.req) begin
        win_valid_s = 1'b1;
        win_grant_s = 1'b1;
      end else begin
        win_valid_s = 1'b0;
      end
    end else begin
      win_valid_s = 1'b0;
    end
    if (win_grant_s) begin
      sel_wr_s    = data_bus.wr;
      sel_size_s  = data_bus.size;
      sel_addr_s  = data_bus.addr;
      sel_wdata_s = data_bus.wdata;
    end else begin
      sel_wr_s    = inst_bus.wr;
      sel_size_s  = inst_bus.size;
      sel_addr_s  = inst_bus.addr;
      sel_wdata_s = inst_bus.wdata;
    end
  end

  // Completion: data_ok counts only while a transaction is on the shared port.
  always_comb begin
    done_s = 1'b0;
    case (state_q)
      ST_ADDR: done_s = mem_bus.addr_ok && mem_bus.data_ok;
      ST_DATA: done_s = mem_bus.data_ok;
      default: done_s = 1'b0;
    endcase
  end

  assign inst_bus.addr_ok = win_valid_s && !win_grant_s;
  assign data_bus.addr_ok = win_valid_s &&  win_grant_s;
  assign inst_bus.data_ok = done_s && !grant_q;
  assign data_bus.data_ok = done_s &&  grant_q;
  assign inst_bus.rdata   = (done_s && !grant_q) ? mem_bus.rdata : {DATA_W{1'b0}};
  assign data_bus.rdata   = (done_s &&  grant_q) ? mem_bus.rdata : {DATA_W{1'b0}};

  assign mem_bus.req   = mem_req_q;
  assign mem_bus.wr    = req_wr_q;
  assign mem_bus.size  = req_size_q;
  assign mem_bus.addr  = req_addr_q;
  assign mem_bus.wdata = req_wdata_q;

  // Transaction FSM; mem_req is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      req_wr_q     <= 1'b0;
      req_size_q   <= 2'd0;
      req_addr_q   <= {ADDR_W{1'b0}};
      req_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid_s) begin
            grant_q      <= win_grant_s;
            last_grant_q <= win_grant_s;
            req_wr_q     <= sel_wr_s;
            req_size_q   <= sel_size_s;
            req_addr_q   <= sel_addr_s;
            req_wdata_q  <= sel_wdata_s;
            mem_req_q    <= 1'b1;
            state_q      <= ST_ADDR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (mem_bus.addr_ok) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_bus.data_ok ? ST_IDLE : ST_DATA;
          end else begin
            state_q <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (mem_bus.data_ok) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DATA;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: expected responses are queued at
// grant time and a negedge monitor matches them against master data_ok.
module tb_sram_like_arbiter;

  typedef struct {
    logic        side;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_bus ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_bus ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_bus (i_bus),
    .data_bus (d_bus),
    .mem_bus  (m_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every master data_ok must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_bus.data_ok || d_bus.data_ok) begin
        if (sb.size() == 0) begin
          chk("unexpected_data_ok", {i_bus.data_ok, d_bus.data_ok}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_ok_side", {i_bus.data_ok, d_bus.data_ok}, e.side ? 2'b01 : 2'b10);
          if (!e.wr) begin
            chk("rdata", e.side ? d_bus.rdata : i_bus.rdata, e.rdata);
          end
        end
      end
      chk("idle_rdata_zero", {i_bus.data_ok ? 32'h0 : i_bus.rdata,
                              d_bus.data_ok ? 32'h0 : d_bus.rdata}, 64'h0);
    end
  end

  // Slave side of one transaction, entered in the first ADDR cycle.
  task automatic serve(input int wait_n, input bit split, input logic [31:0] rd,
                       input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      chk("mem_hold", {m_bus.req, m_bus.wr, m_bus.size, m_bus.addr, m_bus.wdata},
          {1'b1, wr, size, addr, wdata});
      tick();
    end
    m_bus.addr_ok = 1'b1;
    if (!split) begin
      m_bus.data_ok = 1'b1;
      m_bus.rdata   = rd;
    end
    @(negedge clk);
    chk("mem_addr_phase", {m_bus.req, m_bus.wr, m_bus.size, m_bus.addr, m_bus.wdata},
        {1'b1, wr, size, addr, wdata});
    tick();
    m_bus.addr_ok = 1'b0;
    m_bus.data_ok = 1'b0;
    m_bus.rdata   = 32'h0;
    if (split) begin
      m_bus.data_ok = 1'b1;
      m_bus.rdata   = rd;
      @(negedge clk);
      chk("mem_req_low_in_data", m_bus.req, 1'b0);
      tick();
      m_bus.data_ok = 1'b0;
      m_bus.rdata   = 32'h0;
    end
  endtask

  task automatic clear_masters();
    i_bus.req = 1'b0; i_bus.wr = 1'b0; i_bus.size = 2'd2; i_bus.addr = 32'h0; i_bus.wdata = 32'h0;
    d_bus.req = 1'b0; d_bus.wr = 1'b0; d_bus.size = 2'd2; d_bus.addr = 32'h0; d_bus.wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_masters();
    m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = 32'h0;

    // Reset values
    @(negedge clk);
    chk("reset_outputs", {m_bus.req, m_bus.wr, m_bus.size, m_bus.addr, m_bus.wdata,
                          i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok,
                          i_bus.rdata, d_bus.rdata}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single inst read, slave splits addr_ok (cycle 2) and data_ok (cycle 4)
    i_bus.req = 1'b1; i_bus.addr = 32'hBFC0_0000;
    @(negedge clk);
    chk("t1_addr_ok_c0", {i_bus.addr_ok, d_bus.addr_ok, m_bus.req}, 3'b100);
    sb.push_back('{side: 1'b0, wr: 1'b0, rdata: 32'h3C1D_BFC0});
    tick();
    i_bus.req = 1'b0;
    @(negedge clk);
    chk("t1_mem_c1", {i_bus.addr_ok, m_bus.req, m_bus.addr}, {1'b0, 1'b1, 32'hBFC0_0000});
    tick();
    m_bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_mem_c2", {m_bus.req, m_bus.addr}, {1'b1, 32'hBFC0_0000});
    tick();
    m_bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("t1_mem_req_c3", {m_bus.req, i_bus.data_ok}, 2'b00);
    tick();
    m_bus.data_ok = 1'b1; m_bus.rdata = 32'h3C1D_BFC0;
    @(negedge clk);
    chk("t1_inst_data_ok_c4", {i_bus.data_ok, d_bus.data_ok, d_bus.rdata}, {2'b10, 32'h0});
    tick();
    m_bus.data_ok = 1'b0; m_bus.rdata = 32'h0;

    // Both masters request continuously: inst, data, inst, data after reset
    do_reset();
    i_bus.req = 1'b1; i_bus.addr = 32'h1000_0000;
    d_bus.req = 1'b1; d_bus.addr = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      logic        side;
      logic [31:0] a;
      logic [31:0] rd;
      side = i[0];
      a  = side ? d_bus.addr : i_bus.addr;
      rd = side ? (32'hD000_0000 | i) : (32'h1100_0000 | i);
      @(negedge clk);
      chk("t2_grant", {i_bus.addr_ok, d_bus.addr_ok}, side ? 2'b01 : 2'b10);
      sb.push_back('{side: side, wr: 1'b0, rdata: rd});
      tick();
      if (side) d_bus.addr = d_bus.addr + 32'h10;
      else      i_bus.addr = i_bus.addr + 32'h10;
      serve(0, 1'b0, rd, 1'b0, 2'd2, a, 32'h0);
    end
    clear_masters();

    // Data byte write with addr_ok delayed 5 cycles
    d_bus.req = 1'b1; d_bus.wr = 1'b1; d_bus.size = 2'd0;
    d_bus.addr = 32'h8000_0003; d_bus.wdata = 32'h0000_00AB;
    @(negedge clk);
    chk("t3_addr_ok", {i_bus.addr_ok, d_bus.addr_ok}, 2'b01);
    sb.push_back('{side: 1'b1, wr: 1'b1, rdata: 32'h0});
    tick();
    clear_masters();
    serve(5, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);

    // Same-cycle addr_ok/data_ok, then an immediate new grant
    i_bus.req = 1'b1; i_bus.addr = 32'h0000_0100;
    @(negedge clk);
    chk("t4_addr_ok", {i_bus.addr_ok, d_bus.addr_ok}, 2'b10);
    sb.push_back('{side: 1'b0, wr: 1'b0, rdata: 32'hCAFE_0100});
    tick();
    clear_masters();
    serve(0, 1'b0, 32'hCAFE_0100, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    d_bus.req = 1'b1; d_bus.addr = 32'h0000_0500;
    @(negedge clk);
    chk("t4_back_in_idle", {m_bus.req, i_bus.addr_ok, d_bus.addr_ok}, 3'b001);

    // inst requests while the data transaction sits in DATA
    sb.push_back('{side: 1'b1, wr: 1'b0, rdata: 32'hD00D_0005});
    tick();
    d_bus.req = 1'b0;
    i_bus.req = 1'b1; i_bus.addr = 32'h0000_0200;
    m_bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("t5_blocked_addr", i_bus.addr_ok, 1'b0);
    tick();
    m_bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("t5_blocked_data", i_bus.addr_ok, 1'b0);
    tick();
    m_bus.data_ok = 1'b1; m_bus.rdata = 32'hD00D_0005;
    @(negedge clk);
    chk("t5_blocked_done", {i_bus.addr_ok, d_bus.data_ok}, 2'b01);
    tick();
    m_bus.data_ok = 1'b0; m_bus.rdata = 32'h0;
    @(negedge clk);
    chk("t5_granted_after", i_bus.addr_ok, 1'b1);
    sb.push_back('{side: 1'b0, wr: 1'b0, rdata: 32'h1234_0200});
    tick();
    clear_masters();
    serve(0, 1'b0, 32'h1234_0200, 1'b0, 2'd2, 32'h0000_0200, 32'h0);

    // Reset while in DATA abandons the transaction
    i_bus.req = 1'b1; i_bus.addr = 32'h0000_0300;
    tick();
    clear_masters();
    m_bus.addr_ok = 1'b1;
    tick();
    m_bus.addr_ok = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_async_reset", {m_bus.req, m_bus.wr, m_bus.size, m_bus.addr, m_bus.wdata,
                           i_bus.addr_ok, d_bus.addr_ok, i_bus.data_ok, d_bus.data_ok,
                           i_bus.rdata, d_bus.rdata}, 128'h0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    m_bus.data_ok = 1'b1; m_bus.rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("t6_stray_data_ok", {i_bus.data_ok, d_bus.data_ok, m_bus.req}, 3'b000);
    tick();
    m_bus.data_ok = 1'b0; m_bus.rdata = 32'h0;
    tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
